// File: rtl/tx_link_sequencer.sv
// Transmit lane sequencer: chooses one 8b10b character per cycle (commas, idle, SOF/data/EOF).
// Define TX_SKIP_EN to insert a K28.0 clock-compensation skip in idle every SKIP_PERIOD characters.
module tx_link_sequencer #(
  parameter int ALIGN_CNT   = 16,
  parameter int IFG         = 2,
  parameter int SKIP_PERIOD = 1024
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       EN,
  input  logic       S_VALID,
  input  logic [7:0] S_DATA,
  input  logic       S_LAST,
  output logic       S_READY,
  output logic       ENC_DVI,
  output logic       ENC_K,
  output logic [7:0] ENC_DI,
  output logic       ALIGNED
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam int AW = $clog2(ALIGN_CNT + 1);
  localparam int GW = $clog2(IFG + 1);

  typedef enum logic [2:0] {
    ST_OFF, ST_ALIGN, ST_IDLE, ST_SOF, ST_DATA, ST_EOF
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_align_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic          w_gap_ok;
  logic          w_skip_now;

  // An abort cycle replaces the data slot, so nothing is taken while EN is low.
  assign S_READY  = (r_state == ST_DATA) && EN;
  assign w_gap_ok = (r_gap_cnt >= GW'(IFG - 1));

`ifdef TX_SKIP_EN
  localparam int SW = $clog2(SKIP_PERIOD + 1);
  logic [SW-1:0] r_skip_cnt;

  // Counter saturates at SKIP_PERIOD; saturation is the pending flag.
  assign w_skip_now = (r_state == ST_IDLE) && EN && (r_skip_cnt == SW'(SKIP_PERIOD));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_skip_cnt <= '0;
    end else if (r_state == ST_OFF || !EN || w_skip_now) begin
      r_skip_cnt <= '0;
    end else if (r_skip_cnt != SW'(SKIP_PERIOD)) begin
      r_skip_cnt <= r_skip_cnt + 1'b1;
    end
  end
`else
  logic w_skip_period_unused;
  assign w_skip_period_unused = (SKIP_PERIOD > 0);
  assign w_skip_now           = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_OFF;
      r_align_cnt <= '0;
      r_gap_cnt   <= '0;
      ENC_DVI     <= 1'b0;
      ENC_K       <= 1'b0;
      ENC_DI      <= 8'h00;
      ALIGNED     <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          ENC_DVI <= 1'b0;
          ENC_K   <= 1'b0;
          ENC_DI  <= 8'h00;
          ALIGNED <= 1'b0;
          if (EN) begin
            r_state     <= ST_ALIGN;
            r_align_cnt <= '0;
          end
        end
        default: begin
          if (!EN) begin
            r_state <= ST_OFF;
            ALIGNED <= 1'b0;
            if (r_state == ST_SOF || r_state == ST_DATA) begin
              ENC_DVI <= 1'b1;
              ENC_K   <= 1'b1;
              ENC_DI  <= K30_7;
            end else begin
              ENC_DVI <= 1'b0;
              ENC_K   <= 1'b0;
              ENC_DI  <= 8'h00;
            end
          end else begin
            ENC_DVI <= 1'b1;
            ENC_K   <= 1'b1;
            case (r_state)
              ST_ALIGN: begin
                ENC_DI <= K28_5;
                if (r_align_cnt == AW'(ALIGN_CNT - 1)) begin
                  r_state   <= ST_IDLE;
                  r_gap_cnt <= GW'(IFG);
                end else begin
                  r_align_cnt <= r_align_cnt + 1'b1;
                end
              end
              ST_IDLE: begin
                ENC_DI  <= w_skip_now ? K28_0 : K28_5;
                ALIGNED <= 1'b1;
                if (r_gap_cnt != GW'(IFG)) r_gap_cnt <= r_gap_cnt + 1'b1;
                if (S_VALID && w_gap_ok) r_state <= ST_SOF;
              end
              ST_SOF: begin
                ENC_DI  <= K27_7;
                r_state <= ST_DATA;
              end
              ST_DATA: begin
                if (S_VALID) begin
                  ENC_K  <= 1'b0;
                  ENC_DI <= S_DATA;
                  if (S_LAST) r_state <= ST_EOF;
                end else begin
                  ENC_DI <= K23_7;
                end
              end
              ST_EOF: begin
                ENC_DI    <= K29_7;
                r_gap_cnt <= '0;
                r_state   <= ST_IDLE;
              end
              default: begin
                ENC_DVI <= 1'b0;
                ENC_K   <= 1'b0;
                ENC_DI  <= 8'h00;
                r_state <= ST_OFF;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
